pmem_line_responder: RTL and testbench

//  Physical-memory responder for the L2 line interface: serves 128-bit line reads/writes from the L2 cache.

---
 rtl/pmem_line_responder_pkg.sv | 24 ++
 rtl/pmem_line_responder_array.sv | 28 ++
 rtl/pmem_line_responder.sv | 163 ++++++++++++++++
 tb/tb_pmem_line_responder.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_line_responder_pkg.sv
// Shared types and constants for the physical-memory line responder.
// Holds the lc3b_types additions: line/word types, line size and the FSM state enum.
package pmem_line_responder_pkg;

    localparam int unsigned PMEM_LINE_BYTES = 16;
    localparam int unsigned PMEM_LINE_W     = PMEM_LINE_BYTES * 8;
    localparam int unsigned PMEM_CNT_W      = 4;

    typedef logic [15:0]            lc3b_word;
    typedef logic [PMEM_LINE_W-1:0] lc3b_cache_line;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lc3b_pmem_state;

    // Counter preload for a given latency: the ACCESS state spends LATENCY cycles
    // counting from LATENCY-1 down to 0.
    function automatic logic [PMEM_CNT_W-1:0] pmem_latency_load(input int unsigned latency);
        return PMEM_CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/pmem_line_responder_array.sv
// Line-granular backing store: 2**IDX_W x 128-bit single-port array with a
// registered read port. Contents are not reset.
module pmem_line_array
    import pmem_line_responder_pkg::*;
#(
    parameter int unsigned IDX_W = 8
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [IDX_W-1:0]       index_i,
    input  logic [PMEM_LINE_W-1:0] wdata_i,
    output logic [PMEM_LINE_W-1:0] rdata_o
);

    logic [PMEM_LINE_W-1:0] mem_q [2**IDX_W];
    logic [PMEM_LINE_W-1:0] rdata_q;

    // Synchronous write and registered read of the addressed line.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[index_i] <= wdata_i;
        end
        rdata_q <= mem_q[index_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pmem_line_responder.sv
// Physical-memory line responder for the L2 line interface.
// Serves 128-bit line reads/writes with a fixed LATENCY from acceptance to pmem_resp.
// Optional feature macro: PMEM_PROTOCOL_CHECK_EN enables the sticky pmem_err checker;
// without it pmem_err is tied low and no checker logic exists.
module pmem_line_responder
    import pmem_line_responder_pkg::*;
#(
    parameter int unsigned IDX_W   = 8,
    parameter int unsigned LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         pmem_busy,
    output logic         pmem_err
);

    lc3b_pmem_state         state_q, state_d;
    logic [PMEM_CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   op_wr_q, op_wr_d;
    logic [PMEM_LINE_W-1:0] wdata_q, wdata_d;
    logic [PMEM_LINE_W-1:0] rdata_q, rdata_d;
    logic                   hold_q, hold_d;

    logic                   arr_we;
    logic [PMEM_LINE_W-1:0] arr_rdata;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^{pmem_address[3:0], pmem_address[15:IDX_W+4]};

    // FSM, latency counter and request latch registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            op_wr_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            op_wr_q <= op_wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state, request acceptance, commit and response generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        op_wr_d   = op_wr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        hold_d    = 1'b0;
        arr_we    = 1'b0;
        pmem_resp = 1'b0;
        case (state_q)
            IDLE: begin
                // hold_q marks the cycle right after RESP, where a still-high
                // request must not be taken as a new one.
                if (!hold_q && (pmem_read || pmem_write)) begin
                    idx_d   = pmem_address[IDX_W+3:4];
                    op_wr_d = pmem_write;
                    wdata_d = pmem_wdata;
                    cnt_d   = pmem_latency_load(LATENCY);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    arr_we  = op_wr_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                pmem_resp = 1'b1;
                hold_d    = 1'b1;
                state_d   = IDLE;
                if (!op_wr_q) begin
                    rdata_d = arr_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The array read port is free-running on the latched index, so the visible
    // read data is taken from it only in a read RESP and held in rdata_q otherwise.
    assign pmem_rdata = (state_q == RESP && !op_wr_q) ? arr_rdata : rdata_q;
    assign pmem_busy  = (state_q != IDLE);

    pmem_line_array #(
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we & ~rst),
        .index_i (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

`ifdef PMEM_PROTOCOL_CHECK_EN
    logic        err_q, err_d;
    logic [11:0] tag_q, tag_d;
    logic        sample;
    logic        viol;

    assign sample = (state_q == IDLE) && !hold_q;

    // Sticky protocol-violation detection against the latched request.
    always_comb begin
        tag_d = tag_q;
        if (sample && (pmem_read || pmem_write)) begin
            tag_d = pmem_address[15:4];
        end
        viol = 1'b0;
        if (sample && pmem_read && pmem_write) begin
            viol = 1'b1;
        end
        if (state_q == ACCESS) begin
            if (op_wr_q ? !pmem_write : !pmem_read) begin
                viol = 1'b1;
            end
            if (pmem_address[15:4] != tag_q) begin
                viol = 1'b1;
            end
        end
        err_d = err_q | viol;
    end

    // Checker state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            tag_q <= '0;
        end else begin
            err_q <= err_d;
            tag_q <= tag_d;
        end
    end

    assign pmem_err = err_q;
`else
    assign pmem_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Self-checking bench for pmem_line_responder (IDX_W=8, LATENCY=4).
module tb_pmem_line_responder;

    localparam int unsigned LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         resp;
    logic         busy;
    logic         err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [127:0] model [int];
    logic [127:0] last_read;
    logic [15:0]  written [$];
`ifdef PMEM_PROTOCOL_CHECK_EN
    logic exp_err_on = 1'b1;
`else
    logic exp_err_on = 1'b0;
`endif

    always #5 clk = ~clk;

    pmem_line_responder #(
        .IDX_W   (8),
        .LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (rd),
        .pmem_write   (wr),
        .pmem_address (addr),
        .pmem_wdata   (wdata),
        .pmem_rdata   (rdata),
        .pmem_resp    (resp),
        .pmem_busy    (busy),
        .pmem_err     (err)
    );

    function automatic int line_of(input logic [15:0] a);
        return (int'(a) / 16) % 256;
    endfunction

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one request after two idle negedges and waits (bounded) for resp.
    task automatic do_req(input logic r, input logic w, input logic [15:0] a,
                          input logic [127:0] d, input logic chg,
                          input logic [15:0] a2, input logic [127:0] d2,
                          output logic [127:0] got, output int lat);
        @(negedge clk);
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
        lat = 0;
        got = '0;
        while (lat <= 20) begin
            @(negedge clk);
            lat++;
            if (chg && lat == 2) begin
                addr = a2; wdata = d2;
            end
            if (resp) begin
                got = rdata;
                break;
            end
        end
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({resp, busy, err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got resp/busy/err=%b required 000", {resp, busy, err});
        end
        tests_run++;
        if (rdata !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h required 0", rdata);
        end
        rst = 1'b0;
        last_read = '0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy got %b required 0", busy);
        end
    endtask

    task automatic test_t1_write_read();
        logic [127:0] d, got;
        int lat;
        d = {8{16'hA5A5}};
        do_req(1'b0, 1'b1, 16'h1230, d, 1'b0, '0, '0, got, lat);
        model[line_of(16'h1230)] = d;
        tests_run++;
        if (lat != LAT + 1) begin
            tests_failed++;
            $display("FAIL t1_write_latency: got %0d required %0d", lat, LAT + 1);
        end
        @(negedge clk);
        tests_run++;
        if (resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_resp_width: resp got %b required 0 one cycle later", resp);
        end
        do_req(1'b1, 1'b0, 16'h123F, '0, 1'b0, '0, '0, got, lat);
        last_read = got;
        tests_run++;
        if (lat != LAT + 1) begin
            tests_failed++;
            $display("FAIL t1_read_latency: got %0d required %0d", lat, LAT + 1);
        end
        tests_run++;
        if (got !== d) begin
            tests_failed++;
            $display("FAIL t1_read_data: got %h required %h", got, d);
        end
    endtask

    task automatic test_distinct_lines();
        logic [127:0] d1, d2, got;
        int lat;
        d1 = rnd_line();
        d2 = ~d1;
        do_req(1'b0, 1'b1, 16'h0010, d1, 1'b0, '0, '0, got, lat);
        model[line_of(16'h0010)] = d1;
        do_req(1'b0, 1'b1, 16'h0020, d2, 1'b0, '0, '0, got, lat);
        model[line_of(16'h0020)] = d2;
        @(negedge clk);
        tests_run++;
        if (rdata !== last_read) begin
            tests_failed++;
            $display("FAIL rdata_hold: got %h required %h", rdata, last_read);
        end
        do_req(1'b1, 1'b0, 16'h0010, '0, 1'b0, '0, '0, got, lat);
        last_read = got;
        tests_run++;
        if (got !== d1) begin
            tests_failed++;
            $display("FAIL t2_read_0010: got %h required %h", got, d1);
        end
        do_req(1'b1, 1'b0, 16'h0020, '0, 1'b0, '0, '0, got, lat);
        last_read = got;
        tests_run++;
        if (got !== d2) begin
            tests_failed++;
            $display("FAIL t2_read_0020: got %h required %h", got, d2);
        end
    endtask

    task automatic test_alias();
        logic [127:0] d1, d2, got;
        int lat;
        d1 = rnd_line();
        d2 = d1 ^ {4{32'h0F0F_1234}};
        do_req(1'b0, 1'b1, 16'h1010, d2, 1'b0, '0, '0, got, lat);
        model[line_of(16'h1010)] = d2;
        do_req(1'b0, 1'b1, 16'h1000, d1, 1'b0, '0, '0, got, lat);
        model[line_of(16'h1000)] = d1;
        do_req(1'b1, 1'b0, 16'h0000, '0, 1'b0, '0, '0, got, lat);
        last_read = got;
        tests_run++;
        if (got !== d1) begin
            tests_failed++;
            $display("FAIL t3_alias_0000: got %h required %h", got, d1);
        end
        do_req(1'b1, 1'b0, 16'h1010, '0, 1'b0, '0, '0, got, lat);
        last_read = got;
        tests_run++;
        if (got !== d2) begin
            tests_failed++;
            $display("FAIL t3_other_1010: got %h required %h", got, d2);
        end
    endtask

    task automatic test_hold_request();
        int k;
        logic exp_resp, exp_busy;
        @(negedge clk);
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; addr = 16'h0010;
        k = 0;
        while (resp !== 1'b1 && k <= 20) begin
            @(negedge clk);
            k++;
        end
        tests_run++;
        if (k != LAT + 1) begin
            tests_failed++;
            $display("FAIL t4_first_latency: got %0d required %0d", k, LAT + 1);
        end
        // Request stays high: the blocked idle cycle, one sampling idle cycle,
        // then a new transaction whose resp lands LAT+3 cycles after the first.
        for (int i = 1; i <= LAT + 3; i++) begin
            @(negedge clk);
            exp_resp = (i == LAT + 3);
            exp_busy = (i >= 3 && i <= LAT + 3);
            tests_run++;
            if (resp !== exp_resp || busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL t4_hold_cycle%0d: resp/busy got %b%b required %b%b",
                         i, resp, busy, exp_resp, exp_busy);
            end
            if (i == LAT + 3) begin
                tests_run++;
                if (rdata !== model[line_of(16'h0010)]) begin
                    tests_failed++;
                    $display("FAIL t4_second_data: got %h required %h",
                             rdata, model[line_of(16'h0010)]);
                end
                last_read = rdata;
            end
        end
        rd = 1'b0;
        for (int i = 1; i <= LAT + 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (resp !== 1'b0) begin
                tests_failed++;
                $display("FAIL t4_no_extra_resp cycle%0d: got %b required 0", i, resp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] old_d, new_d, got;
        int lat;
        old_d = rnd_line();
        do_req(1'b0, 1'b1, 16'h0040, old_d, 1'b0, '0, '0, got, lat);
        model[line_of(16'h0040)] = old_d;
        for (int v = 0; v < 2; v++) begin
            new_d = ~old_d;
            @(negedge clk);
            @(negedge clk);
            wr = 1'b1; addr = 16'h0040; wdata = new_d;
            // v=0: early in ACCESS; v=1: the cycle whose closing edge would commit.
            repeat ((v == 0) ? 2 : LAT) @(negedge clk);
            rst = 1'b1; wr = 1'b0;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                tests_run++;
                if (resp !== 1'b0 || busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL t5_in_reset v%0d: resp/busy got %b%b required 00", v, resp, busy);
                end
            end
            rst = 1'b0;
            last_read = '0;
            do_req(1'b1, 1'b0, 16'h0040, '0, 1'b0, '0, '0, got, lat);
            last_read = got;
            tests_run++;
            if (got !== old_d) begin
                tests_failed++;
                $display("FAIL t5_old_data v%0d: got %h required %h", v, got, old_d);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] d, got;
        logic [15:0]  a;
        int lat;
        for (int n = 0; n < 40; n++) begin
            if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
                a = 16'($urandom);
                d = rnd_line();
                do_req(1'b0, 1'b1, a, d, 1'b0, '0, '0, got, lat);
                model[line_of(a)] = d;
                written.push_back(a);
            end else begin
                a = written[$urandom_range(0, written.size() - 1)];
                a = {4'($urandom), a[11:4], 4'($urandom)};
                do_req(1'b1, 1'b0, a, '0, 1'b0, '0, '0, got, lat);
                last_read = got;
                tests_run++;
                if (got !== model[line_of(a)]) begin
                    tests_failed++;
                    $display("FAIL rand_read %h: got %h required %h", a, got, model[line_of(a)]);
                end
            end
            tests_run++;
            if (lat != LAT + 1) begin
                tests_failed++;
                $display("FAIL rand_latency op%0d: got %0d required %0d", n, lat, LAT + 1);
            end
        end
    endtask

    task automatic test_protocol();
        logic [127:0] d, e, old_b, got;
        int lat;
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t6_err_initial: got %b required 0", err);
        end
        d = rnd_line();
        do_req(1'b1, 1'b1, 16'h0250, d, 1'b0, '0, '0, got, lat);
        model[line_of(16'h0250)] = d;
        tests_run++;
        if (err !== exp_err_on) begin
            tests_failed++;
            $display("FAIL t6_err_both: got %b required %b", err, exp_err_on);
        end
        do_req(1'b1, 1'b0, 16'h0250, '0, 1'b0, '0, '0, got, lat);
        last_read = got;
        tests_run++;
        if (got !== d) begin
            tests_failed++;
            $display("FAIL t6_write_wins: got %h required %h", got, d);
        end
        tests_run++;
        if (err !== exp_err_on) begin
            tests_failed++;
            $display("FAIL t6_err_sticky: got %b required %b", err, exp_err_on);
        end
        // Reset clears the flag; then a mid-ACCESS address/data change must set it
        // while the latched address and data are still the ones used.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_read = '0;
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t6_err_cleared: got %b required 0", err);
        end
        old_b = rnd_line();
        do_req(1'b0, 1'b1, 16'h0400, old_b, 1'b0, '0, '0, got, lat);
        model[line_of(16'h0400)] = old_b;
        d = rnd_line();
        e = ~d;
        do_req(1'b0, 1'b1, 16'h0300, d, 1'b1, 16'h0400, e, got, lat);
        model[line_of(16'h0300)] = d;
        tests_run++;
        if (err !== exp_err_on) begin
            tests_failed++;
            $display("FAIL t6_err_addr_change: got %b required %b", err, exp_err_on);
        end
        do_req(1'b1, 1'b0, 16'h0300, '0, 1'b0, '0, '0, got, lat);
        tests_run++;
        if (got !== d) begin
            tests_failed++;
            $display("FAIL t6_latched_data: got %h required %h", got, d);
        end
        do_req(1'b1, 1'b0, 16'h0400, '0, 1'b0, '0, '0, got, lat);
        last_read = got;
        tests_run++;
        if (got !== old_b) begin
            tests_failed++;
            $display("FAIL t6_other_line_intact: got %h required %h", got, old_b);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL t6_err_reset_again: got %b required 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_t1_write_read();
        test_distinct_lines();
        test_alias();
        test_hold_request();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
